// File: rtl/b2s_receiver.sv
// b2s single-wire bus receiver.
// Decodes low-pulse-width frames into WIDTH-bit words.
`timescale 1ns/1ps
module b2s_receiver #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LOW1_MAX  = 15,
  parameter int unsigned START_MAX = 25,
  parameter int unsigned LOW0_MAX  = 40,
  parameter int unsigned HIGH_MAX  = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b2s_din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned NW = 10;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [NW-1:0] L1_LIM = NW'(LOW1_MAX);
  localparam logic [NW-1:0] ST_LIM = NW'(START_MAX);
  localparam logic [NW-1:0] L0_LIM = NW'(LOW0_MAX);
  localparam logic [NW-1:0] LO_SAT = NW'(LOW0_MAX + 1);
  localparam logic [NW-1:0] HI_LIM = NW'(HIGH_MAX);
  localparam logic [NW-1:0] HI_SAT = NW'(HIGH_MAX + 1);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_s1;
  logic             r_s2;
  logic             r_s2_d;
  logic [NW-1:0]    r_low_cnt;
  logic [NW-1:0]    r_high_cnt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nx;
  logic             r_rst_err;
  logic             w_restart;
  logic             w_load;
  logic             w_rise;
  logic             w_c1;
  logic             w_cst;
  logic             w_c0;
  logic             w_hto;

  // Two-flop synchronizer plus one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_d <= 1'b1;
    end else begin
      r_s1   <= b2s_din;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  // Saturating low/high run-length counters on the synced line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_cnt  <= '0;
      r_high_cnt <= '0;
    end else if (!r_s2) begin
      if (r_s2_d)
        r_low_cnt <= NW'(1);
      else if (r_low_cnt != LO_SAT)
        r_low_cnt <= r_low_cnt + NW'(1);
    end else begin
      if (!r_s2_d)
        r_high_cnt <= NW'(1);
      else if (r_high_cnt != HI_SAT)
        r_high_cnt <= r_high_cnt + NW'(1);
    end
  end

  // Pulse classification, valid on the rise cycle
  always_comb begin
    w_rise = r_s2 & ~r_s2_d;
    w_c1   = (r_low_cnt != '0) && (r_low_cnt <= L1_LIM);
    w_cst  = (r_low_cnt > L1_LIM) && (r_low_cnt <= ST_LIM);
    w_c0   = (r_low_cnt > ST_LIM) && (r_low_cnt <= L0_LIM);
    w_hto  = r_s2 & r_s2_d & (r_high_cnt > HI_LIM);
  end

  // Frame FSM next-state and datapath controls
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_restart  = 1'b0;
    w_load     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise && w_cst)
          w_state_nx = S_HDR;
      end
      S_HDR: begin
        w_cnt_nx = '0;
        if (w_hto)
          w_state_nx = S_ERR;
        else if (!r_s2)
          w_state_nx = S_BIT;
      end
      S_BIT: begin
        if (w_rise) begin
          if (w_c1 || w_c0) begin
            w_shift_nx = {w_c1, r_shift[WIDTH-1:1]};
            w_cnt_nx   = r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              w_state_nx = S_DONE;
              w_load     = 1'b1;
            end
          end else if (w_cst) begin
            w_restart  = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_HDR;
          end else begin
            w_state_nx = S_ERR;
          end
        end else if (w_hto) begin
          w_state_nx = S_ERR;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      S_ERR:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM state, bit counter, shift register and output word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_rst_err <= 1'b0;
      dout      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_shift   <= w_shift_nx;
      r_rst_err <= w_restart;
      if (w_load)
        dout <= w_shift_nx;
    end
  end

  // Status pulses decoded from the registered state
  always_comb begin
    busy       = (r_state == S_HDR) || (r_state == S_BIT);
    dout_valid = (r_state == S_DONE);
    frame_err  = (r_state == S_ERR) || r_rst_err;
  end

endmodule
